// File: rtl/pipe_controller_pkg.sv
// Shared encodings for the pipeline controller: opcodes, funct codes and the
// select codes carried by the stage registers.
package pipe_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU codes are sized at the use site to the ALU_SEL_W parameter
  localparam int ALU_NOP = 0;
  localparam int ALU_ADD = 1;
  localparam int ALU_SUB = 2;
  localparam int ALU_AND = 3;
  localparam int ALU_OR  = 4;
  localparam int ALU_SLT = 5;
  localparam int ALU_LUI = 6;

  localparam int REG_LINK = 31;

  typedef enum logic [1:0] {DST_NOP = 2'd0, DST_RD = 2'd1, DST_RT = 2'd2, DST_R31 = 2'd3} dst_sel_e;
  typedef enum logic [1:0] {BR_NOP = 2'd0, BR_BEQ = 2'd1, BR_BNE = 2'd2} br_sel_e;
  typedef enum logic [1:0] {J_NOP = 2'd0, J_J = 2'd1, J_JAL = 2'd2} j_sel_e;
  typedef enum logic [1:0] {WB_NOP = 2'd0, WB_ALU = 2'd1, WB_MEM = 2'd2, WB_PC8 = 2'd3} wb_sel_e;
  typedef enum logic {RT_REG = 1'b0, RT_IMME = 1'b1} rt_sel_e;

  typedef struct packed {
    logic    reg_ena;
    logic    mem_ena;
    logic    is_load;
    rt_sel_e rt_sel;
    wb_sel_e wb_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{reg_ena: 1'b0, mem_ena: 1'b0, is_load: 1'b0,
                                 rt_sel: RT_REG, wb_sel: WB_NOP};

endpackage

// File: rtl/pipe_decoder.sv
// Combinational ID-stage decode of opcode/funct into the control bundle.
module pipe_decoder
  import pipe_controller_pkg::*;
#(
  parameter int ALU_SEL_W = 4
) (
  input  logic [5:0]           op,
  input  logic [5:0]           func,
  input  logic                 id_valid,
  output dst_sel_e             dst_sel,
  output br_sel_e              branch_sel,
  output j_sel_e               j_sel,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output ctrl_t                ctrl,
  output logic                 uses_rs,
  output logic                 uses_rt,
  output logic                 illegal
);

  logic r_ok;

  always_comb begin
    dst_sel    = DST_NOP;
    branch_sel = BR_NOP;
    j_sel      = J_NOP;
    alu_sel    = ALU_SEL_W'(ALU_NOP);
    ctrl       = CTRL_NOP;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    illegal    = 1'b0;
    r_ok       = 1'b1;
    if (id_valid) begin
      case (op)
        OP_RTYPE: begin
          case (func)
            FN_ADD:  alu_sel = ALU_SEL_W'(ALU_ADD);
            FN_SUB:  alu_sel = ALU_SEL_W'(ALU_SUB);
            FN_AND:  alu_sel = ALU_SEL_W'(ALU_AND);
            FN_OR:   alu_sel = ALU_SEL_W'(ALU_OR);
            FN_SLT:  alu_sel = ALU_SEL_W'(ALU_SLT);
            default: r_ok    = 1'b0;
          endcase
          if (r_ok) begin
            dst_sel      = DST_RD;
            uses_rs      = 1'b1;
            uses_rt      = 1'b1;
            ctrl.reg_ena = 1'b1;
            ctrl.wb_sel  = WB_ALU;
          end else begin
            illegal = 1'b1;
          end
        end
        OP_ADDI, OP_ORI: begin
          dst_sel      = DST_RT;
          uses_rs      = 1'b1;
          alu_sel      = (op == OP_ORI) ? ALU_SEL_W'(ALU_OR) : ALU_SEL_W'(ALU_ADD);
          ctrl.reg_ena = 1'b1;
          ctrl.rt_sel  = RT_IMME;
          ctrl.wb_sel  = WB_ALU;
        end
        OP_LUI: begin
          dst_sel      = DST_RT;
          alu_sel      = ALU_SEL_W'(ALU_LUI);
          ctrl.reg_ena = 1'b1;
          ctrl.rt_sel  = RT_IMME;
          ctrl.wb_sel  = WB_ALU;
        end
        OP_LW: begin
          dst_sel      = DST_RT;
          uses_rs      = 1'b1;
          alu_sel      = ALU_SEL_W'(ALU_ADD);
          ctrl.reg_ena = 1'b1;
          ctrl.is_load = 1'b1;
          ctrl.rt_sel  = RT_IMME;
          ctrl.wb_sel  = WB_MEM;
        end
        OP_SW: begin
          uses_rs      = 1'b1;
          uses_rt      = 1'b1;
          alu_sel      = ALU_SEL_W'(ALU_ADD);
          ctrl.mem_ena = 1'b1;
          ctrl.rt_sel  = RT_IMME;
        end
        OP_BEQ, OP_BNE: begin
          uses_rs    = 1'b1;
          uses_rt    = 1'b1;
          alu_sel    = ALU_SEL_W'(ALU_SUB);
          branch_sel = (op == OP_BNE) ? BR_BNE : BR_BEQ;
        end
        OP_J: j_sel = J_J;
        OP_JAL: begin
          j_sel        = J_JAL;
          dst_sel      = DST_R31;
          ctrl.reg_ena = 1'b1;
          ctrl.wb_sel  = WB_PC8;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipeline control: ID decode, EX/MEM/WB control registers and load-use stall.
module pipe_controller
  import pipe_controller_pkg::*;
#(
  parameter int ALU_SEL_W  = 4,
  parameter int REG_ADDR_W = 5,
  parameter int HAZARD_EN  = 1
) (
  input  logic                  W_clk,
  input  logic                  W_rst,
  input  logic [5:0]            W_op,
  input  logic [5:0]            W_func,
  input  logic [REG_ADDR_W-1:0] W_rs,
  input  logic [REG_ADDR_W-1:0] W_rt,
  input  logic [REG_ADDR_W-1:0] W_rd,
  input  logic                  W_id_valid,
  input  logic                  W_flush,
  output logic [1:0]            R_w_dst_sel,
  output logic [1:0]            R_branch_sel,
  output logic [1:0]            R_j_sel,
  output logic                  R_stall,
  output logic                  R_illegal,
  output logic                  R_ex_rt_sel,
  output logic [ALU_SEL_W-1:0]  R_ex_alu_sel,
  output logic                  R_mem_w_mem_ena,
  output logic                  R_wb_w_reg_ena,
  output logic [1:0]            R_wb_sel,
  output logic [REG_ADDR_W-1:0] R_wb_dst
);

  dst_sel_e             dec_dst_sel;
  br_sel_e              dec_br;
  j_sel_e               dec_j;
  logic [ALU_SEL_W-1:0] dec_alu;
  ctrl_t                dec_ctrl;
  logic                 dec_uses_rs, dec_uses_rt, dec_illegal;

  pipe_decoder #(.ALU_SEL_W(ALU_SEL_W)) u_dec (
    .op        (W_op),
    .func      (W_func),
    .id_valid  (W_id_valid),
    .dst_sel   (dec_dst_sel),
    .branch_sel(dec_br),
    .j_sel     (dec_j),
    .alu_sel   (dec_alu),
    .ctrl      (dec_ctrl),
    .uses_rs   (dec_uses_rs),
    .uses_rt   (dec_uses_rt),
    .illegal   (dec_illegal)
  );

  logic [REG_ADDR_W-1:0] id_dst;
  ctrl_t                 id_ctrl;
  logic                  ld_hit, bubble;

  ctrl_t                 ex_ctrl;
  logic [ALU_SEL_W-1:0]  ex_alu;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic                  mem_reg_ena, mem_mem_ena;
  wb_sel_e               mem_wb_sel;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic                  wb_reg_ena;
  wb_sel_e               wb_sel;
  logic [REG_ADDR_W-1:0] wb_dst;

  always_comb begin
    case (dec_dst_sel)
      DST_RD:  id_dst = W_rd;
      DST_RT:  id_dst = W_rt;
      DST_R31: id_dst = REG_ADDR_W'(REG_LINK);
      default: id_dst = '0;
    endcase
  end

  // r0 is hardwired, so a write to it is dropped here and never reaches WB
  always_comb begin
    id_ctrl         = dec_ctrl;
    id_ctrl.reg_ena = dec_ctrl.reg_ena && (id_dst != '0);
  end

  assign ld_hit  = ex_ctrl.is_load && (ex_dst != '0) &&
                   ((dec_uses_rs && (W_rs == ex_dst)) || (dec_uses_rt && (W_rt == ex_dst)));
  assign R_stall = (HAZARD_EN != 0) && ld_hit;
  assign bubble  = R_stall || W_flush;

  assign R_w_dst_sel  = dec_dst_sel;
  assign R_branch_sel = bubble ? BR_NOP : dec_br;
  assign R_j_sel      = bubble ? J_NOP  : dec_j;
  assign R_illegal    = dec_illegal;

  always_ff @(posedge W_clk) begin
    if (W_rst) begin
      ex_ctrl     <= CTRL_NOP;
      ex_alu      <= '0;
      ex_dst      <= '0;
      mem_reg_ena <= 1'b0;
      mem_mem_ena <= 1'b0;
      mem_wb_sel  <= WB_NOP;
      mem_dst     <= '0;
      wb_reg_ena  <= 1'b0;
      wb_sel      <= WB_NOP;
      wb_dst      <= '0;
    end else begin
      if (bubble) begin
        ex_ctrl <= CTRL_NOP;
        ex_alu  <= '0;
        ex_dst  <= '0;
      end else begin
        ex_ctrl <= id_ctrl;
        ex_alu  <= dec_alu;
        ex_dst  <= id_dst;
      end
      mem_reg_ena <= ex_ctrl.reg_ena;
      mem_mem_ena <= ex_ctrl.mem_ena;
      mem_wb_sel  <= ex_ctrl.wb_sel;
      mem_dst     <= ex_dst;
      wb_reg_ena  <= mem_reg_ena;
      wb_sel      <= mem_wb_sel;
      wb_dst      <= mem_dst;
    end
  end

  assign R_ex_rt_sel     = ex_ctrl.rt_sel;
  assign R_ex_alu_sel    = ex_alu;
  assign R_mem_w_mem_ena = mem_mem_ena;
  assign R_wb_w_reg_ena  = wb_reg_ena;
  assign R_wb_sel        = wb_sel;
  assign R_wb_dst        = wb_dst;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: a reference model queues the expected
// ID/EX/MEM/WB outputs per cycle and a negedge monitor compares them.
module tb_pipe_controller;
  import pipe_controller_pkg::*;

  localparam int HZ = 1;

  logic       W_clk = 1'b0;
  logic       W_rst = 1'b1;
  logic [5:0] W_op = '0, W_func = '0;
  logic [4:0] W_rs = '0, W_rt = '0, W_rd = '0;
  logic       W_id_valid = 1'b0, W_flush = 1'b0;
  logic [1:0] R_w_dst_sel, R_branch_sel, R_j_sel, R_wb_sel;
  logic       R_stall, R_illegal, R_ex_rt_sel, R_mem_w_mem_ena, R_wb_w_reg_ena;
  logic [3:0] R_ex_alu_sel;
  logic [4:0] R_wb_dst;

  pipe_controller #(.ALU_SEL_W(4), .REG_ADDR_W(5), .HAZARD_EN(HZ)) dut (
    .W_clk(W_clk), .W_rst(W_rst), .W_op(W_op), .W_func(W_func),
    .W_rs(W_rs), .W_rt(W_rt), .W_rd(W_rd), .W_id_valid(W_id_valid), .W_flush(W_flush),
    .R_w_dst_sel(R_w_dst_sel), .R_branch_sel(R_branch_sel), .R_j_sel(R_j_sel),
    .R_stall(R_stall), .R_illegal(R_illegal), .R_ex_rt_sel(R_ex_rt_sel),
    .R_ex_alu_sel(R_ex_alu_sel), .R_mem_w_mem_ena(R_mem_w_mem_ena),
    .R_wb_w_reg_ena(R_wb_w_reg_ena), .R_wb_sel(R_wb_sel), .R_wb_dst(R_wb_dst)
  );

  always #5 W_clk = ~W_clk;

  int cyc = 0;
  always @(posedge W_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int due; int dsel; int br; int j; int ill; int stall; } id_exp_t;
  typedef struct { int due; int rt_sel; int alu; } ex_exp_t;
  typedef struct { int due; int mem_ena; } mem_exp_t;
  typedef struct { int due; int reg_ena; int wsel; int dst; } wb_exp_t;

  id_exp_t  q_id[$];
  ex_exp_t  q_ex[$];
  mem_exp_t q_mem[$];
  wb_exp_t  q_wb[$];

  // instruction semantics: dk = destination kind (0 none, 1 rd, 2 rt, 3 link)
  typedef struct { bit legal; bit rs; bit rt; int dk; bit ld; bit st; int br; int j; int alu; bit imm; int wb; } info_t;

  function automatic info_t ref_dec(logic [5:0] op, logic [5:0] fn, logic v);
    info_t i;
    i = '{legal: 1'b0, rs: 1'b0, rt: 1'b0, dk: 0, ld: 1'b0, st: 1'b0, br: 0, j: 0, alu: 0, imm: 1'b0, wb: 0};
    if (!v) return i;
    case (op)
      6'h00: begin
        i.legal = 1'b1;
        case (fn)
          6'h20: i.alu = ALU_ADD;
          6'h22: i.alu = ALU_SUB;
          6'h24: i.alu = ALU_AND;
          6'h25: i.alu = ALU_OR;
          6'h2A: i.alu = ALU_SLT;
          default: i.legal = 1'b0;
        endcase
        if (i.legal) begin i.rs = 1; i.rt = 1; i.dk = 1; i.wb = WB_ALU; end
      end
      6'h08: begin i.legal = 1; i.rs = 1; i.dk = 2; i.alu = ALU_ADD; i.imm = 1; i.wb = WB_ALU; end
      6'h0D: begin i.legal = 1; i.rs = 1; i.dk = 2; i.alu = ALU_OR;  i.imm = 1; i.wb = WB_ALU; end
      6'h0F: begin i.legal = 1; i.dk = 2; i.alu = ALU_LUI; i.imm = 1; i.wb = WB_ALU; end
      6'h23: begin i.legal = 1; i.rs = 1; i.dk = 2; i.ld = 1; i.alu = ALU_ADD; i.imm = 1; i.wb = WB_MEM; end
      6'h2B: begin i.legal = 1; i.rs = 1; i.rt = 1; i.st = 1; i.alu = ALU_ADD; i.imm = 1; end
      6'h04: begin i.legal = 1; i.rs = 1; i.rt = 1; i.alu = ALU_SUB; i.br = BR_BEQ; end
      6'h05: begin i.legal = 1; i.rs = 1; i.rt = 1; i.alu = ALU_SUB; i.br = BR_BNE; end
      6'h02: begin i.legal = 1; i.j = J_J; end
      6'h03: begin i.legal = 1; i.j = J_JAL; i.dk = 3; i.wb = WB_PC8; end
      default: i.legal = 1'b0;
    endcase
    return i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model of what sits in EX right now (needed for load-use prediction)
  bit       m_ld  = 1'b0;
  int       m_dst = 0;

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic v,
                      input logic fl, input logic rst, output bit stalled);
    info_t    i;
    int       c, dst;
    bit       st, bub;
    id_exp_t  ei;
    ex_exp_t  ee;
    mem_exp_t em;
    wb_exp_t  ew;
    @(posedge W_clk); #1;
    W_op = op; W_func = fn; W_rs = rs; W_rt = rt; W_rd = rd;
    W_id_valid = v; W_flush = fl; W_rst = rst;
    c = cyc;
    i = ref_dec(op, fn, v);
    case (i.dk)
      1: dst = int'(rd);
      2: dst = int'(rt);
      3: dst = 31;
      default: dst = 0;
    endcase
    st  = (HZ != 0) && m_ld && (m_dst != 0) &&
          ((i.rs && int'(rs) == m_dst) || (i.rt && int'(rt) == m_dst));
    bub = st || fl;
    ei.due = c; ei.br = bub ? 0 : i.br; ei.j = bub ? 0 : i.j;
    ei.ill = (v && !i.legal) ? 1 : 0; ei.stall = st ? 1 : 0;
    case (i.dk)
      1: ei.dsel = DST_RD;
      2: ei.dsel = DST_RT;
      3: ei.dsel = DST_R31;
      default: ei.dsel = DST_NOP;
    endcase
    q_id.push_back(ei);
    if (rst) begin
      while (q_ex.size()  > 0 && q_ex[$].due  > c) q_ex.delete(q_ex.size() - 1);
      while (q_mem.size() > 0 && q_mem[$].due > c) q_mem.delete(q_mem.size() - 1);
      while (q_wb.size()  > 0 && q_wb[$].due  > c) q_wb.delete(q_wb.size() - 1);
      ee = '{due: c + 1, rt_sel: 0, alu: 0};
      q_ex.push_back(ee);
      for (int k = 1; k <= 2; k++) begin em = '{due: c + k, mem_ena: 0}; q_mem.push_back(em); end
      for (int k = 1; k <= 3; k++) begin ew = '{due: c + k, reg_ena: 0, wsel: 0, dst: 0}; q_wb.push_back(ew); end
      m_ld = 0; m_dst = 0;
    end else if (bub) begin
      ee = '{due: c + 1, rt_sel: 0, alu: 0};           q_ex.push_back(ee);
      em = '{due: c + 2, mem_ena: 0};                  q_mem.push_back(em);
      ew = '{due: c + 3, reg_ena: 0, wsel: 0, dst: 0}; q_wb.push_back(ew);
      m_ld = 0; m_dst = 0;
    end else begin
      ee = '{due: c + 1, rt_sel: i.imm ? 1 : 0, alu: i.alu}; q_ex.push_back(ee);
      em = '{due: c + 2, mem_ena: i.st ? 1 : 0};             q_mem.push_back(em);
      ew = '{due: c + 3, reg_ena: (i.dk != 0 && dst != 0) ? 1 : 0, wsel: i.wb, dst: dst};
      q_wb.push_back(ew);
      m_ld = i.ld; m_dst = dst;
    end
    stalled = st;
  endtask

  always @(negedge W_clk) begin : monitor
    id_exp_t  ei;
    ex_exp_t  ee;
    mem_exp_t em;
    wb_exp_t  ew;
    if (q_id.size() > 0 && q_id[0].due == cyc) begin
      ei = q_id.pop_front();
      chk("id_dst_sel", 32'(R_w_dst_sel), ei.dsel);
      chk("id_branch_sel", 32'(R_branch_sel), ei.br);
      chk("id_j_sel", 32'(R_j_sel), ei.j);
      chk("id_illegal", 32'(R_illegal), ei.ill);
      chk("stall", 32'(R_stall), ei.stall);
    end
    if (q_ex.size() > 0 && q_ex[0].due == cyc) begin
      ee = q_ex.pop_front();
      chk("ex_rt_sel", 32'(R_ex_rt_sel), ee.rt_sel);
      chk("ex_alu_sel", 32'(R_ex_alu_sel), ee.alu);
    end
    if (q_mem.size() > 0 && q_mem[0].due == cyc) begin
      em = q_mem.pop_front();
      chk("mem_w_mem_ena", 32'(R_mem_w_mem_ena), em.mem_ena);
    end
    if (q_wb.size() > 0 && q_wb[0].due == cyc) begin
      ew = q_wb.pop_front();
      chk("wb_reg_ena", 32'(R_wb_w_reg_ena), ew.reg_ena);
      chk("wb_sel", 32'(R_wb_sel), ew.wsel);
      chk("wb_dst", 32'(R_wb_dst), ew.dst);
    end
  end

  logic [5:0] ops [11] = '{6'h00, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
  logic [5:0] fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

  initial begin
    bit s, prev_fl;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic v, fl, rst;

    step(0, 0, 0, 0, 0, 0, 0, 1, s);
    step(0, 0, 0, 0, 0, 0, 0, 1, s);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, s);

    // ADD r3,r1,r2
    step(6'h00, 6'h20, 1, 2, 3, 1, 0, 0, s);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, s);
    // LW r5 then ADD r6,r5,r1: one stall, ADD retried
    step(6'h23, 0, 1, 5, 0, 1, 0, 0, s);
    step(6'h00, 6'h20, 5, 1, 6, 1, 0, 0, s);
    step(6'h00, 6'h20, 5, 1, 6, 1, 0, 0, s);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, s);
    // LW r0 then ADD r6,r0,r1: no stall, no write
    step(6'h23, 0, 1, 0, 0, 1, 0, 0, s);
    step(6'h00, 6'h20, 0, 1, 6, 1, 0, 0, s);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, s);
    // JAL, then illegal opcode
    step(6'h03, 0, 0, 0, 0, 1, 0, 0, s);
    step(6'h3F, 0, 1, 2, 3, 1, 0, 0, s);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, s);
    // flushed SW
    step(6'h2B, 0, 1, 2, 0, 1, 1, 0, s);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, s);
    // reset while stalled
    step(6'h23, 0, 1, 5, 0, 1, 0, 0, s);
    step(6'h00, 6'h20, 5, 1, 6, 1, 0, 1, s);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, s);

    s = 0; prev_fl = 0;
    op = 0; fn = 0; rs = 0; rt = 0; rd = 0; v = 0;
    for (int n = 0; n < 600; n++) begin
      if (!(s && !prev_fl)) begin
        op = ops[$urandom_range(0, 10)];
        fn = fns[$urandom_range(0, 5)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        v  = ($urandom_range(0, 9) != 0);
      end
      fl  = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 79) == 0);
      step(op, fn, rs, rt, rd, v, fl, rst, s);
      prev_fl = fl || rst;
    end

    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, s);
    repeat (4) @(negedge W_clk);
    #1;
    chk("scoreboard_drained", 32'(q_id.size() + q_ex.size() + q_mem.size() + q_wb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
